// File: rtl/pair_triple_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : pair_triple_monitor_if
// Description : Signal bundle between a stimulus source (master) and the
//               pair/triple detection monitor (slave).
//               en        - sample enable (master -> slave)
//               det_n     - detector output, active-low detection
//               clear     - synchronous clear of monitor state
//               evt_count - saturating detection event count (slave -> master)
//               alarm     - sticky alarm flag
//               run_len   - current consecutive detection run length
// Revision    : 1.0 - initial release
// ============================================================================
interface pair_triple_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             det_n;
  logic             clear;
  logic [CNT_W-1:0] evt_count;
  logic             alarm;
  logic [7:0]       run_len;

  modport master (
    output en, det_n, clear,
    input  evt_count, alarm, run_len
  );

  modport slave (
    input  en, det_n, clear,
    output evt_count, alarm, run_len
  );
endinterface
`default_nettype wire

// File: rtl/pair_triple_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pair_triple_monitor
// Description : Samples the pair/triple detector output under an enable,
//               counts rising detection events in a saturating counter and
//               raises a sticky alarm once a detection persists for THRESH
//               consecutive enabled samples.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               mon   - slave side of pair_triple_monitor_if
//                       (en, det_n, clear in; evt_count, alarm, run_len out)
// Parameters  : THRESH (1..255) run length that raises the alarm
//               CNT_W  (1..16)  event counter width
// Revision    : 1.0 - initial release
// ============================================================================
module pair_triple_monitor #(
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pair_triple_monitor_if.slave mon
);

  localparam logic [7:0]       THRESH_V = 8'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  state_t           state;
  logic             prev_det;
  logic [CNT_W-1:0] evt_cnt;
  logic [7:0]       run_cnt;
  logic             alarm_flag;

  logic             det;
  logic [7:0]       run_next;

  assign det      = ~mon.det_n;
  assign run_next = run_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_det   <= 1'b0;
      evt_cnt    <= '0;
      run_cnt    <= 8'd0;
      alarm_flag <= 1'b0;
    end else if (mon.clear) begin
      // Clear discards the sample taken on this edge, so a detection still
      // present afterwards counts as a fresh event.
      state      <= IDLE;
      prev_det   <= 1'b0;
      evt_cnt    <= '0;
      run_cnt    <= 8'd0;
      alarm_flag <= 1'b0;
    end else if (mon.en) begin
      prev_det <= det;

      // Events are counted in every state, including ALARM.
      if (det && !prev_det && (evt_cnt != CNT_MAX)) begin
        evt_cnt <= evt_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (det) begin
            run_cnt <= 8'd1;
            if (THRESH_V == 8'd1) begin
              state      <= ALARM;
              alarm_flag <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (det) begin
            run_cnt <= run_next;
            if (run_next == THRESH_V) begin
              state      <= ALARM;
              alarm_flag <= 1'b1;
            end
          end else begin
            run_cnt <= 8'd0;
            state   <= IDLE;
          end
        end
        ALARM: begin
          // Sticky until clear or reset; run_cnt remains at THRESH.
          state      <= ALARM;
          alarm_flag <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          run_cnt    <= 8'd0;
          alarm_flag <= 1'b0;
        end
      endcase
    end
  end

  assign mon.evt_count = evt_cnt;
  assign mon.alarm     = alarm_flag;
  assign mon.run_len   = run_cnt;

endmodule
`default_nettype wire

// File: doc/pair_triple_monitor.md
# pair_triple_monitor

Sequential monitor that sits directly downstream of the pair/triple detector and consumes its single-bit output. It samples the detector output under an enable, counts distinct detection events in a saturating counter, and raises a sticky alarm when a detection persists for THRESH consecutive enabled samples. The alarm and the counter are cleared together by a synchronous clear.

## Interface

- THRESH, default 3: number of consecutive enabled detection samples that raises the alarm; legal range 1..255.
- CNT_W, default 8: width of the event counter; legal range 1..16.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; detector output is ignored on edges where en=0.
- det_n  input  1  detector output; 0 = two or three inputs high (detection), 1 = at most one input high.
- clear  input  1  synchronous clear of the alarm, the counters and the history.
- evt_count  output  CNT_W  number of detection events since reset/clear, saturating.
- alarm  output  1  sticky alarm flag.
- run_len  output  8  current consecutive-detection run length, saturating at THRESH.

## Operation

- A sample is a rising edge with en=1. det = ~det_n on that edge.
- prev_det register: updated to det on every sample; holds when en=0.
- Event: a sample with det=1 and prev_det=0. Each event increments evt_count by 1. At 2^CNT_W-1 the count holds (no wrap). Events are counted in every state, including ALARM.
- FSM states are IDLE, RUN and ALARM. alarm=1 exactly when the state is ALARM.
  - IDLE: a sample with det=1 sets run_len=1. The next state is ALARM if THRESH=1, otherwise RUN. A sample with det=0 keeps the FSM in IDLE.
  - RUN: a sample with det=1 increments run_len. When run_len reaches THRESH, the next state is ALARM. A sample with det=0 sets run_len=0 and the next state is IDLE.
  - ALARM: held until clear, regardless of det or en. run_len holds at THRESH. Events continue to be counted.
  - en=0 in any state: state, run_len and prev_det hold.
- clear=1 on an edge overrides everything:
  - state→IDLE; evt_count, run_len and prev_det go to 0.
  - The det sample on that edge is discarded.
  - If det_n stays 0 after the clear, the next sample is a new event and starts a new run at run_len=1.
- Reset (rst_n=0) forces the same values as clear, asynchronously and without a clock. Deassertion is synchronous to clk. Reset in the middle of a run or in ALARM discards all history.

## Timing

- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Reset values: evt_count=0, alarm=0, run_len=0; state=IDLE; prev_det=0.
- evt_count updates on the edge that samples the event and is visible in the following cycle.
- alarm rises on the edge that takes the THRESH-th consecutive enabled detection sample. Minimum latency is THRESH edges from the first detection sample.
- alarm falls on the edge where clear=1. Clearing takes exactly one cycle.
- Simultaneous clear and event: clear wins, so evt_count=0 on the next cycle, not 1.
- Simultaneous saturation and event: the count holds at the maximum.

## Test plan

- Async reset: drive to ALARM with evt_count=2, then pull rst_n low between edges → alarm=0, evt_count=0 and run_len=0 immediately. After release, det_n=0 for 3 enabled edges → alarm=1.
- Basic run (THRESH=3, en=1), det_n = 1,0,0,0,1,1 → evt_count becomes 1 after the 2nd edge. alarm becomes 1 after the 4th edge and stays 1 through the trailing 1s.
- Broken run (THRESH=3), det_n = 0,0,1,0,0,1 → alarm remains 0 and evt_count=2. run_len sequence is 1,2,0,1,2,0.
- Enable gaps (THRESH=3), det_n held 0 with en = 1,0,1,0,1 → run_len goes 1,1,2,2,3, alarm rises after the 5th edge, and evt_count=1.
- Clear under held detection: in ALARM with det_n=0, pulse clear for one cycle with en=1 → the next cycle shows alarm=0, evt_count=0, run_len=0. The following enabled edge gives evt_count=1 and run_len=1. alarm is set again after 3 edges total.
- Saturation (CNT_W=2, THRESH=255): 5 separate events (det_n alternating 0,1) → evt_count goes 1,2,3,3,3 and alarm remains 0.
